mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the cpu instruction-fetch port (pc/instr) and its data port (aluout/writedata/readdata/memwrite).
- Round-robin FSM arbitration.
- Registered memory-side outputs.
- Watchdog timeout on slow or unresponsive memory.
- Sits between cpu and memory; drives a stall the cpu/datapath uses to freeze the pc.

Parameters:
n, 16, data and address width (matches cpu n)
TIMEOUT, 15, max cycles in a grant state without mem_ready before abort (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held high until if_ack
if_addr  input  n  fetch address (pc); stable while if_req high
if_rdata  output  n  fetched instruction; valid when if_ack is high, held until next fetch ack
if_ack  output  1  one-cycle fetch completion pulse
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store, 0 = load; stable with d_req
d_addr  input  n  data address (aluout)
d_wdata  input  n  store data (writedata)
d_rdata  output  n  load data; valid when d_ack is high, held until next data ack
d_ack  output  1  one-cycle data completion pulse
mem_req  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  n  memory address
mem_wdata  output  n  memory write data
mem_rdata  input  n  memory read data, valid with mem_ready
mem_ready  input  1  memory completes current access this cycle
stall  output  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational
err  output  1  one-cycle pulse, same cycle as the ack of an aborted access

Behaviour:
- Clock and reset: single clock `clk`; synchronous active-high `reset`. All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE; mem_req=mem_we=0; mem_addr=mem_wdata=0.
  - if_ack=d_ack=err=0; if_rdata=d_rdata=0.
  - watchdog=0; last_grant=DATA, so fetch wins the first tie.
- Reset asserted mid-access: the access is dropped with no ack and no err. The memory sees mem_req fall the next cycle.
- States:
  - IDLE: no access in progress.
  - FETCH: fetch access outstanding.
  - DATA: data access outstanding.
- Eligibility in IDLE: requester X is eligible if X_req=1 and X_ack=0 this cycle. The ack cycle masks the still-high req, so one request gives one access.
- Grant decision in IDLE:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: capture addr/we/wdata into mem_* registers, set mem_req=1 (mem_we=d_we only for DATA, else 0), update last_grant, clear watchdog, move to the grant state.
- FETCH/DATA:
  - mem_* held constant.
  - watchdog increments each cycle mem_ready=0.
  - On mem_ready=1: capture mem_rdata into the granted requester's rdata (a store also captures it, value is don't-care), pulse its ack next cycle, mem_req=mem_we=0, go to IDLE.
  - On watchdog==TIMEOUT with mem_ready=0: abort. Pulse the granted ack and err next cycle, rdata unchanged, mem_req=0, go to IDLE.
- Latency:
  - Grant (mem_req high) 1 cycle after an eligible req in IDLE.
  - Ack 1 cycle after mem_ready.
  - Zero-wait memory: req to ack = 2 cycles; back-to-back same requester = 3 cycles per access.
- mem_ready while IDLE is ignored.
- Requester change of addr/wdata while granted is ignored; the captured value is used.
- Watchdog width is $clog2(TIMEOUT+1); no wrap possible, abort precedes overflow.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins (normal completion, err=0).
- Acks are mutually exclusive; err never asserts without an ack.

Decomposition:
- Shared package mem_arbiter_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, FETCH, DATA};
  - typedef enum logic grant_t {GNT_FETCH, GNT_DATA};
- No sub-module is needed. FSM, round-robin flag and watchdog live in one module: one next-state always_comb, one always_ff register block.

Test Plan:
- Reset with if_req=d_req=1 held: all outputs 0. First grant after reset release is FETCH (mem_addr=if_addr).
- Fetch only, if_addr=16'h0004, mem_ready 1 cycle after mem_req, mem_rdata=16'h1234: if_ack pulses 2 cycles after req, if_rdata=16'h1234, mem_we=0.
- Both req high continuously, zero-wait memory: grants alternate FETCH, DATA, FETCH. Each ack is single-cycle and stall stays 1 until the respective ack.
- Store d_we=1, d_addr=16'h0010, d_wdata=16'hBEEF, memory waits 3 cycles: mem_we=1 and mem_wdata=16'hBEEF held 4 cycles, then d_ack.
- Memory never ready, TIMEOUT=15: d_ack and err pulse together after watchdog reaches 15, d_rdata unchanged. Next request is served normally.
- Reset asserted on the 2nd wait cycle of a fetch: no if_ack, mem_req=0 next cycle, state IDLE. A ready=1 arriving during reset causes no capture.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and grant helper for the fetch/data memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_t;

    // Round-robin pick: on a tie the requester not served last wins.
    // Only meaningful when at least one requester is eligible.
    function automatic grant_t pick_grant(
        input logic   fetch_ok,
        input logic   data_ok,
        input grant_t last
    );
        if (fetch_ok && data_ok) begin
            return (last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (data_ok) begin
            return GNT_DATA;
        end else begin
            return GNT_FETCH;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory between fetch and data ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int n       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic [n-1:0] if_rdata,
    output logic         if_ack,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic [n-1:0] d_rdata,
    output logic         d_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic         stall,
    output logic         err
);

    localparam int             WDW    = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    arb_state_t     state_q, state_d;
    grant_t         last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic           mem_req_d, mem_we_d;
    logic [n-1:0]   mem_addr_d, mem_wdata_d;
    logic           if_ack_d, d_ack_d, err_d;
    logic [n-1:0]   if_rdata_d, d_rdata_d;

    logic           if_elig, d_elig;
    grant_t         winner;

    // The ack cycle masks a still-high request so one request yields one access.
    assign if_elig = if_req && !if_ack;
    assign d_elig  = d_req && !d_ack;
    assign winner  = pick_grant(if_elig, d_elig, last_q);

    // Requester is stalled from request until its ack pulse.
    assign stall = (if_req && !if_ack) || (d_req && !d_ack);

    // Next-state logic: grant in IDLE, complete or abort in the grant states.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wd_d        = wd_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ready is ignored here; only a fresh request starts an access.
                if (if_elig || d_elig) begin
                    mem_req_d = 1'b1;
                    wd_d      = '0;
                    last_d    = winner;
                    if (winner == GNT_DATA) begin
                        state_d     = DATA;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d    = FETCH;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end

            FETCH, DATA: begin
                // mem_ready takes priority over a timeout landing in the same cycle.
                if (mem_ready) begin
                    if (state_q == FETCH) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end else if (wd_q == WD_MAX) begin
                    // Abort: ack the stuck requester with err, leave its rdata alone.
                    if (state_q == FETCH) begin
                        if_ack_d = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                    end
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any access in flight silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= GNT_DATA;
            wd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_ack    <= if_ack_d;
            d_ack     <= d_ack_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int N       = 16;
    localparam int TIMEOUT = 15;
    localparam int CYCLES  = 3000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         if_req = 1'b0;
    logic [N-1:0] if_addr = '0;
    logic [N-1:0] if_rdata;
    logic         if_ack;
    logic         d_req = 1'b0;
    logic         d_we = 1'b0;
    logic [N-1:0] d_addr = '0;
    logic [N-1:0] d_wdata = '0;
    logic [N-1:0] d_rdata;
    logic         d_ack;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         stall;
    logic         err;

    mem_arbiter #(.n(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference state: a memory image, pending requests, and the outstanding access.
    logic [N-1:0] ref_mem [16];
    bit           pend_if, pend_d;
    logic [N-1:0] rq_if_addr, rq_d_addr, rq_d_wdata;
    bit           rq_d_we;
    bit           busy;
    int           who;          // 0 = fetch, 1 = data
    int           last_served;  // 0 = fetch, 1 = data
    int           waitcnt, lat_left, rst_cycles;
    bit           did_mid_reset;
    bit           e_if, e_d, prev_if_ack, prev_d_ack;
    bit           exp_if_ack, exp_d_ack, exp_err, exp_mem_req, exp_mem_we, exp_stall;
    logic [N-1:0] exp_if_rdata, exp_d_rdata, exp_mem_addr, exp_mem_wdata, drv_rdata;
    int           r;

    function automatic logic [N-1:0] rand_addr();
        logic [N-1:0] a;
        a = N'($urandom);
        if ($urandom_range(0, 3) != 0) a[N-1:4] = '0;
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = N'($urandom);
        busy = 0; who = 0; last_served = 1; waitcnt = 0; lat_left = 0;
        exp_if_ack = 0; exp_d_ack = 0; exp_err = 0; exp_mem_req = 0; exp_mem_we = 0;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_mem_addr = '0; exp_mem_wdata = '0;
        did_mid_reset = 0;

        // Both requesters held high through reset; fetch must win the first tie.
        pend_if = 1; rq_if_addr = 16'h0004;
        pend_d = 1; rq_d_addr = 16'h0010; rq_d_we = 1; rq_d_wdata = 16'hBEEF;
        if_req = 1; if_addr = rq_if_addr;
        d_req = 1; d_addr = rq_d_addr; d_we = rq_d_we; d_wdata = rq_d_wdata;
        reset = 1;
        rst_cycles = 3;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);

            // Compare every observable output against the model's prediction.
            exp_stall = (pend_if && !exp_if_ack) || (pend_d && !exp_d_ack);
            chk("if_ack",    N'(if_ack),    N'(exp_if_ack));
            chk("d_ack",     N'(d_ack),     N'(exp_d_ack));
            chk("err",       N'(err),       N'(exp_err));
            chk("stall",     N'(stall),     N'(exp_stall));
            chk("mem_req",   N'(mem_req),   N'(exp_mem_req));
            chk("mem_we",    N'(mem_we),    N'(exp_mem_we));
            chk("mem_addr",  mem_addr,      exp_mem_addr);
            chk("mem_wdata", mem_wdata,     exp_mem_wdata);
            chk("if_rdata",  if_rdata,      exp_if_rdata);
            chk("d_rdata",   d_rdata,       exp_d_rdata);

            // Requesters: retire on ack, then maybe issue a new request.
            if (exp_if_ack) pend_if = 0;
            if (exp_d_ack)  pend_d  = 0;
            if (!pend_if && $urandom_range(0, 3) != 0) begin
                pend_if = 1;
                rq_if_addr = rand_addr();
            end
            if (!pend_d && $urandom_range(0, 3) != 0) begin
                pend_d = 1;
                rq_d_addr = rand_addr();
                rq_d_we = 1'($urandom_range(0, 1));
                rq_d_wdata = N'($urandom);
            end
            if_req = pend_if;
            d_req  = pend_d;
            // A granted requester's address/data may wander; the captured copy must be used.
            if_addr = (busy && who == 0) ? N'($urandom) : rq_if_addr;
            d_addr  = (busy && who == 1) ? N'($urandom) : rq_d_addr;
            d_wdata = (busy && who == 1) ? N'($urandom) : rq_d_wdata;
            d_we    = rq_d_we;

            // Reset: initial hold, plus one assertion in the middle of a fetch wait.
            reset = 0;
            if (rst_cycles > 0) begin
                reset = 1;
                rst_cycles--;
            end else if (!did_mid_reset && cyc > 1500 && busy && who == 0
                         && waitcnt == 1 && lat_left >= 1) begin
                reset = 1;
                rst_cycles = 1;
                did_mid_reset = 1;
            end

            // Memory agent.
            drv_rdata = N'($urandom);
            if (reset) begin
                mem_ready = 1;
            end else if (busy) begin
                if (lat_left == 0) begin
                    mem_ready = 1;
                    if (who == 0 || !rq_d_we) begin
                        drv_rdata = ref_mem[exp_mem_addr[3:0]];
                    end else begin
                        ref_mem[exp_mem_addr[3:0]] = exp_mem_wdata;
                    end
                end else begin
                    mem_ready = 0;
                    lat_left--;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = drv_rdata;

            // Predict what the coming clock edge produces.
            if (reset) begin
                busy = 0; last_served = 1;
                exp_if_ack = 0; exp_d_ack = 0; exp_err = 0;
                exp_if_rdata = '0; exp_d_rdata = '0;
                exp_mem_we = 0; exp_mem_addr = '0; exp_mem_wdata = '0;
            end else begin
                prev_if_ack = exp_if_ack;
                prev_d_ack  = exp_d_ack;
                exp_if_ack = 0; exp_d_ack = 0; exp_err = 0;
                if (busy) begin
                    if (mem_ready) begin
                        if (who == 0) begin
                            exp_if_rdata = drv_rdata; exp_if_ack = 1;
                        end else begin
                            exp_d_rdata = drv_rdata; exp_d_ack = 1;
                        end
                        busy = 0; last_served = who; exp_mem_we = 0;
                    end else begin
                        waitcnt++;
                        if (waitcnt == TIMEOUT + 1) begin
                            if (who == 0) exp_if_ack = 1;
                            else          exp_d_ack  = 1;
                            exp_err = 1;
                            busy = 0; last_served = who; exp_mem_we = 0;
                        end
                    end
                end else begin
                    e_if = pend_if && !prev_if_ack;
                    e_d  = pend_d && !prev_d_ack;
                    if (e_if || e_d) begin
                        if (e_if && e_d) who = (last_served == 0) ? 1 : 0;
                        else             who = e_d ? 1 : 0;
                        busy = 1;
                        waitcnt = 0;
                        if (who == 0) begin
                            exp_mem_addr = rq_if_addr;
                            exp_mem_we = 0;
                        end else begin
                            exp_mem_addr = rq_d_addr;
                            exp_mem_we = rq_d_we;
                            exp_mem_wdata = rq_d_wdata;
                        end
                        r = $urandom_range(0, 9);
                        if (r < 7)       lat_left = $urandom_range(0, 3);
                        else if (r == 7) lat_left = TIMEOUT;
                        else if (r == 8) lat_left = TIMEOUT + 1;
                        else             lat_left = 100;
                    end
                end
            end
            exp_mem_req = busy;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
